// File: rtl/alu_rr_arbiter_if.sv
// Request/response bundle between two requesters, the shared-ALU arbiter and the result consumer.
// The master side is the requesters plus the consumer; the slave side is the arbiter.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req1_valid;
  logic             req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one add/subtract ALU between two requesters.
// Flow: grant in IDLE, one EXEC cycle through the ALU, then hold the tagged result in RESP.

module alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // Add when op is 1, otherwise a - b; the result wraps modulo 2^WIDTH
  always_comb begin
    if (op) begin
      y = a + b;
    end else begin
      y = a - b;
    end
  end
endmodule

module alu_rr_arbiter #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  alu_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_r;
  logic             op_r;
  logic             id_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             rsp_valid_r;
  logic             rsp_id_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             busy_r;
  logic [WIDTH-1:0] alu_y_s;
  logic             grant_valid_s;
  logic             grant_id_s;
  logic             grant_ok_s;

  // Pick the requester to serve; on a tie the one not served last wins
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = ~last_r;
    end else if (bus.req0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b0;
    end else if (bus.req1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = 1'b1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  // rst_n gating keeps both readies low while reset is held
  assign grant_ok_s     = rst_n && (state_r == ST_IDLE) && grant_valid_s;
  assign bus.req0_ready = grant_ok_s && !grant_id_s;
  assign bus.req1_ready = grant_ok_s && grant_id_s;

  alu_addsub #(.WIDTH(WIDTH)) u_alu (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .y  (alu_y_s)
  );

  // Control FSM with request latch and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_r       <= 1'b1;
      op_r         <= 1'b0;
      id_r         <= 1'b0;
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_ok_s) begin
            op_r    <= grant_id_s ? bus.req1_op : bus.req0_op;
            a_r     <= grant_id_s ? bus.req1_a  : bus.req0_a;
            b_r     <= grant_id_s ? bus.req1_b  : bus.req0_b;
            id_r    <= grant_id_s;
            last_r  <= grant_id_s;
            busy_r  <= 1'b1;
            state_r <= ST_EXEC;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          rsp_result_r <= alu_y_s;
          rsp_id_r     <= id_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.busy       = busy_r;
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: a vector table of single transactions plus
// hand-written stall, streaming and mid-operation reset sequences.
module tb_alu_rr_arbiter;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_rr_arbiter_if #(.WIDTH(8)) bus ();

  alu_rr_arbiter #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic       op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic       op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       exp_id;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction from IDLE with rsp_ready high: grant, EXEC, RESP, consume.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    bus.req0_valid = v.v0; bus.req0_op = v.op0; bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_valid = v.v1; bus.req1_op = v.op1; bus.req1_a = v.a1; bus.req1_b = v.b1;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("grant", 32'({bus.req1_ready, bus.req0_ready}), v.exp_id ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("exec_busy", 32'(bus.busy), 32'd1);
    chk("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(v.exp_id));
    chk("rsp_result", 32'(bus.rsp_result), 32'(v.exp_res));
    @(posedge clk); #1;
    chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("held_result", 32'(bus.rsp_result), 32'(v.exp_res));
  endtask

  // Hold the chosen valids high (req0 add 05,03 -> 08, req1 sub 10,01 -> 0F)
  // and collect n responses; handshakes must be exactly 3 cycles apart.
  task automatic stream(input logic v0, input logic v1, input logic [7:0] exp_ids, input int n);
    int cyc;
    int got;
    int last_hs;
    logic hs_id;
    cyc = 0; got = 0; last_hs = -1;
    @(negedge clk);
    bus.req0_op = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h03;
    bus.req1_op = 1'b0; bus.req1_a = 8'h10; bus.req1_b = 8'h01;
    bus.req0_valid = v0; bus.req1_valid = v1; bus.rsp_ready = 1'b1;
    #1;
    while (got < n && cyc < 60) begin
      if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
        hs_id = bus.req1_ready;
        chk("stream_grant", 32'(hs_id), 32'(exp_ids[got]));
        if (last_hs >= 0) chk("stream_spacing", 32'(cyc - last_hs), 32'd3);
        last_hs = cyc;
      end
      if (bus.rsp_valid) begin
        chk("stream_id", 32'(bus.rsp_id), 32'(exp_ids[got]));
        chk("stream_result", 32'(bus.rsp_result), exp_ids[got] ? 32'h0f : 32'h08);
        got++;
      end
      if (got < n) begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{1'b1, 1'b1, 8'h05, 8'h03, 1'b1, 1'b0, 8'h10, 8'h01, 1'b0, 8'h08};
    vecs[1] = '{1'b0, 1'b1, 8'h05, 8'h03, 1'b1, 1'b0, 8'h10, 8'h01, 1'b1, 8'h0f};
    vecs[2] = '{1'b1, 1'b1, 8'hff, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1, 8'hff};
    vecs[4] = '{1'b1, 1'b0, 8'h03, 8'h05, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 8'hfe};
    vecs[5] = '{1'b1, 1'b0, 8'h03, 8'h05, 1'b1, 1'b1, 8'h80, 8'h80, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h7f, 8'h01, 1'b1, 8'h80};
    vecs[7] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h55, 8'haa, 1'b0, 8'h46};
    vecs[8] = '{1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h55, 8'haa, 1'b1, 8'hab};

    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.rsp_ready  = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-pressure: response must hold for 5 stalled cycles while req1 waits
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_a = 8'h01; bus.req0_b = 8'h02;
    bus.req1_valid = 1'b1; bus.req1_op = 1'b0; bus.req1_a = 8'h10; bus.req1_b = 8'h01;
    bus.rsp_ready  = 1'b0;
    #1;
    chk("stall_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("stall_rsp_result", 32'(bus.rsp_result), 32'h03);
      chk("stall_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
      chk("stall_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("unstall_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("unstall_busy", 32'(bus.busy), 32'd0);
    chk("unstall_idle_grant", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
    bus.req1_valid = 1'b0;

    stream(1'b0, 1'b1, 8'b0000_0111, 3);
    stream(1'b1, 1'b1, 8'b0000_1010, 4);

    // Reset while in EXEC discards the operation
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_op = 1'b1; bus.req0_a = 8'h05; bus.req0_b = 8'h03;
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    bus.req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.rsp_valid || bus.busy) seen++;
      end
      chk("no_rsp_after_reset", 32'(seen), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
